// File: rtl/rv_uart_tx.sv
// rv_uart_tx: memory-mapped UART transmitter (FIFO + 8N1 serialiser, LSB first).
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.

// uart_tx_fifo: generic synchronous FIFO, extra pointer MSB tells full from empty.
// Latency: a pushed entry is visible on rd_dat the cycle after the push.
// Backpressure: wr_vld ignored while full, rd_rdy ignored while empty.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_rdy && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_vld && !full) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

// rv_uart_tx: bus slave feeding a TX FIFO that drives a serial frame engine.
// Latency: bus response 1 cycle after req; start bit 2 cycles after a push into an idle unit.
// Backpressure: none on the bus; pushes into a full FIFO are dropped and flagged in OVF.
module rv_uart_tx #(
  parameter int XLEN        = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              tx_o,
  output logic              irq_o
);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_BIT = 1'b1;
`else
  localparam logic PAR_BIT = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_wr, reload;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_d, ovf_q, busy, bit_end;
  logic        fifo_full, fifo_empty, fifo_pop, push_req;
  logic [7:0]  fifo_rd_dat;
  logic [1:0]  sel;
  logic        acc_wr;
  logic [XLEN-1:0] rd_val;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif

  logic unused_bits;
  assign unused_bits = ^{data_addr_i[XLEN-1:4], data_addr_i[1:0],
                         data_wdata_i[XLEN-1:16], data_be_i[XLEN/8-1:2]};

  assign sel      = data_addr_i[3:2];
  assign acc_wr   = data_req_i & data_we_i;
  assign push_req = acc_wr && (sel == 2'd0) && data_be_i[0];
  assign busy     = (state_q != S_IDLE);
  assign irq_o    = fifo_empty & ~busy;
  assign bit_end  = (cnt_q == 16'd0);
  assign reload   = div_q - 16'd1;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .wr_vld (push_req),
    .wr_dat (data_wdata_i[7:0]),
    .rd_rdy (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    div_wr = div_q;
    if (data_be_i[0]) div_wr[7:0]  = data_wdata_i[7:0];
    if (data_be_i[1]) div_wr[15:8] = data_wdata_i[15:8];
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      2'd1:    rd_val = {{(XLEN-5){1'b0}}, PAR_BIT, ovf_q, fifo_empty, fifo_full, busy};
      2'd2:    rd_val = {{(XLEN-16){1'b0}}, div_q};
      default: rd_val = '0;
    endcase
  end

  // Overflow is judged on FULL before any same-cycle pop frees a slot.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      ovf_q         <= 1'b0;
      div_q         <= 16'(DEFAULT_DIV);
    end else begin
      data_rvalid_o <= data_req_i;
      data_rdata_o  <= (data_req_i && !data_we_i) ? rd_val : '0;
      if (push_req && fifo_full)
        ovf_q <= 1'b1;
      else if (acc_wr && (sel == 2'd1) && data_be_i[0] && data_wdata_i[3])
        ovf_q <= 1'b0;
      if (acc_wr && (sel == 2'd2))
        div_q <= (div_wr == 16'd0) ? 16'd1 : div_wr;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      tx_o    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_o    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (busy && !bit_end) cnt_d = cnt_q - 16'd1;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        shift_d  = fifo_rd_dat;
`ifdef UART_TX_PARITY_EN
        par_d    = ^fifo_rd_dat;
`endif
        cnt_d    = reload;
        state_d  = S_START;
      end
      S_START: if (bit_end) begin
        cnt_d   = reload;
        bit_d   = 3'd0;
        state_d = S_DATA;
      end
      S_DATA: if (bit_end) begin
        cnt_d = reload;
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) begin
        cnt_d   = reload;
        state_d = S_STOP;
      end
`endif
      // Chaining straight into the next START avoids an idle gap between frames.
      S_STOP: if (bit_end) begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_dat;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_rd_dat;
`endif
          cnt_d    = reload;
          state_d  = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end
endmodule
